// File: rtl/usb_rx_deserializer.sv
// usb_rx_deserializer: USB full-speed receive front-end (line decode, SYNC, NRZI, unstuff, bytes, EOP).
// Define USB_RX_CRC16_EN to check the CRC16 residual of DATA packets at EOP.
module usb_rx_deserializer #(
    parameter int MAX_BYTES = 1027
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_stb,
    input  logic       d_p,
    input  logic       d_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error,
    output logic [2:0] err_code
);
    localparam int BW = $clog2(MAX_BYTES + 2);
    localparam logic [BW-1:0] BYTE_LAST = BW'(MAX_BYTES);
    localparam logic [2:0] IDLE = 3'd0, HUNT = 3'd1, DATA = 3'd2, EOP = 3'd3, ERR_WAIT = 3'd4;
    logic [2:0] state, hunt_cnt, ones, bit_cnt, err;
    logic [6:0] hunt_sr, sr;
    logic [7:0] byte_nxt;
    logic [BW-1:0] byte_cnt;
    logic prev_j, jcnt, line_j, line_k, line_se0, dbit, sync_hit, crc_ok;
    assign line_j = d_p & ~d_n;
    assign line_k = ~d_p & d_n;
    assign line_se0 = ~d_p & ~d_n;
    assign dbit = line_j == prev_j;
    assign byte_nxt = {dbit, sr};
    assign sync_hit = {hunt_sr, dbit} == 8'h01;
    // abort reason for the current strobe; SE1 falls through as a stuff error
    assign err = state == DATA ?
                     (line_se0 ? ((bit_cnt != 3'd0 || byte_cnt == '0) ? 3'd2 : 3'd0)
                      : !(line_j || line_k) ? 3'd1
                      : ones == 3'd6 ? (dbit ? 3'd1 : 3'd0)
                      : bit_cnt != 3'd7 ? 3'd0
                      : byte_cnt == '0 ? (byte_nxt[7:4] == ~byte_nxt[3:0] ? 3'd0 : 3'd3)
                      : byte_cnt == BYTE_LAST ? 3'd4 : 3'd0)
                 : state == EOP ? (line_se0 ? 3'd0 : line_j ? (crc_ok ? 3'd0 : 3'd5) : 3'd2)
                 : 3'd0;
`ifdef USB_RX_CRC16_EN
    logic [15:0] crc;
    logic is_data, take;
    assign take = bit_stb && state == DATA && (line_j || line_k) && ones != 3'd6;
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= 16'hFFFF;
            is_data <= 1'b0;
        end else if (bit_stb && state == HUNT) begin
            crc <= 16'hFFFF;
        end else if (take) begin
            if (byte_cnt != '0) crc <= {crc[14:0], 1'b0} ^ ((dbit ^ crc[15]) ? 16'h8005 : 16'h0000);
            if (byte_cnt == '0 && bit_cnt == 3'd7) is_data <= &byte_nxt[1:0];
        end
    end
    assign crc_ok = !is_data || crc == 16'h800D;
`else
    assign crc_ok = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prev_j <= 1'b1;
            hunt_sr <= '0;
            hunt_cnt <= '0;
            ones <= '0;
            bit_cnt <= '0;
            sr <= '0;
            byte_cnt <= '0;
            jcnt <= 1'b0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            rx_active <= 1'b0;
            rx_eop <= 1'b0;
            rx_error <= 1'b0;
            err_code <= '0;
        end else begin
            rx_valid <= 1'b0;
            rx_eop <= 1'b0;
            rx_error <= 1'b0;
            if (bit_stb) begin
                if (line_j || line_k) prev_j <= line_j;
                if (err != 3'd0) begin
                    state <= ERR_WAIT;
                    jcnt <= 1'b0;
                    rx_active <= 1'b0;
                    rx_error <= 1'b1;
                    err_code <= err;
                end else begin
                    case (state)
                        IDLE: if (line_k && prev_j) begin
                            state <= HUNT;
                            hunt_sr <= '0;
                            hunt_cnt <= 3'd1;
                        end
                        HUNT: if (line_se0) state <= IDLE;
                        else if (line_j || line_k) begin
                            hunt_sr <= {hunt_sr[5:0], dbit};
                            hunt_cnt <= hunt_cnt + 3'd1;
                            if (hunt_cnt == 3'd7) begin
                                state <= sync_hit ? DATA : IDLE;
                                rx_active <= sync_hit;
                                err_code <= sync_hit ? 3'd0 : err_code;
                                ones <= 3'd1;
                                bit_cnt <= '0;
                                byte_cnt <= '0;
                            end
                        end
                        DATA: if (line_se0) state <= EOP;
                        else if (ones == 3'd6) ones <= 3'd0;
                        else begin
                            ones <= dbit ? ones + 3'd1 : 3'd0;
                            sr <= byte_nxt[7:1];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data <= byte_nxt;
                                rx_valid <= 1'b1;
                                byte_cnt <= byte_cnt + BW'(1);
                            end
                        end
                        EOP: if (line_j) begin
                            state <= IDLE;
                            rx_active <= 1'b0;
                            rx_eop <= 1'b1;
                        end
                        ERR_WAIT: begin
                            jcnt <= line_j;
                            if (line_j && jcnt) state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_deserializer.sv
// tb_usb_rx_deserializer: directed bench; a second instance with MAX_BYTES=4 covers overflow.
module tb_usb_rx_deserializer;
    logic clk = 1'b0, rst = 1'b1, bit_stb = 1'b0, d_p = 1'b1, d_n = 1'b0;
    logic [7:0] rx_data, rx_data4;
    logic rx_valid, rx_active, rx_eop, rx_error, rx_valid4, rx_active4, rx_eop4, rx_error4;
    logic [2:0] err_code, err_code4;
    int n_checks = 0, n_fail = 0;
    logic [7:0] got[$], got4[$];
    int n_eop, n_err, n_err4, n_bad;
    logic [2:0] last_code, code4;
    logic line_j = 1'b1;
    int ones = 0;
    logic post_valid, post_active, post_eop, post_err;

    usb_rx_deserializer dut (
        .clk(clk), .rst(rst), .bit_stb(bit_stb), .d_p(d_p), .d_n(d_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
        .rx_eop(rx_eop), .rx_error(rx_error), .err_code(err_code)
    );
    usb_rx_deserializer #(.MAX_BYTES(4)) dut4 (
        .clk(clk), .rst(rst), .bit_stb(bit_stb), .d_p(d_p), .d_n(d_n),
        .rx_data(rx_data4), .rx_valid(rx_valid4), .rx_active(rx_active4),
        .rx_eop(rx_eop4), .rx_error(rx_error4), .err_code(err_code4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst) begin
        if (rx_valid) got.push_back(rx_data);
        if (rx_eop) n_eop++;
        if (rx_error) begin
            n_err++;
            last_code = err_code;
        end
        if (int'(rx_valid) + int'(rx_eop) + int'(rx_error) > 1 || (rx_valid && !rx_active) ||
            ((rx_eop || rx_error) && rx_active)) n_bad++;
        if (rx_valid4) got4.push_back(rx_data4);
        if (rx_error4) begin
            n_err4++;
            code4 = err_code4;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clr();
        got.delete();
        got4.delete();
        n_eop = 0;
        n_err = 0;
        n_err4 = 0;
        n_bad = 0;
        last_code = 3'd0;
        code4 = 3'd0;
    endtask

    task automatic strobe(input logic dp, input logic dn);
        @(negedge clk);
        d_p = dp;
        d_n = dn;
        bit_stb = 1'b1;
        @(negedge clk);
        bit_stb = 1'b0;
        post_valid = rx_valid;
        post_active = rx_active;
        post_eop = rx_eop;
        post_err = rx_error;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            line_j = 1'b1;
            strobe(1'b1, 1'b0);
        end
    endtask

    task automatic send_bit(input logic b);
        if (!b) line_j = ~line_j;
        strobe(line_j, ~line_j);
    endtask

    task automatic send_dbit(input logic b);
        send_bit(b);
        if (b) begin
            ones++;
            if (ones == 6) begin
                send_bit(1'b0);
                ones = 0;
            end
        end else ones = 0;
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
        ones = 1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_dbit(v[i]);
    endtask

    task automatic send_eop();
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        line_j = 1'b1;
        strobe(1'b1, 1'b0);
    endtask

    // wire-order CRC16 bytes for a two-byte payload: [7:0] sent first
    function automatic logic [15:0] crc16(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] c, d, r;
        c = 16'hFFFF;
        d = {b, a};
        for (int i = 0; i < 16; i++) c = {c[14:0], 1'b0} ^ ((d[i] ^ c[15]) ? 16'h8005 : 16'h0000);
        for (int i = 0; i < 16; i++) r[i] = ~c[15-i];
        return r;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_data, rx_valid, rx_active, rx_eop, rx_error, err_code} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected 0", {rx_data, rx_valid, rx_active, rx_eop, rx_error, err_code});
        end
        rst = 1'b0;
    endtask

    task automatic test_ack();
        clr();
        idle(3);
        send_sync();
        n_checks++;
        if (post_active !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_active_rise: got %b expected 1", post_active);
        end
        send_byte(8'hD2);
        n_checks++;
        if (post_valid !== 1'b1 || rx_data !== 8'hD2) begin
            n_fail++;
            $display("FAIL ack_valid: got valid=%b data=%h expected valid=1 data=d2", post_valid, rx_data);
        end
        send_eop();
        n_checks++;
        if (post_eop !== 1'b1 || post_active !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_eop: got eop=%b active=%b expected eop=1 active=0", post_eop, post_active);
        end
        n_checks++;
        if (got.size() != 1 || n_eop != 1 || n_err != 0 || n_bad != 0) begin
            n_fail++;
            $display("FAIL ack_counts: got bytes=%0d eop=%0d err=%0d bad=%0d expected 1 1 0 0",
                     got.size(), n_eop, n_err, n_bad);
        end
    endtask

    task automatic test_data0_stuffing();
        logic [15:0] c;
        logic [7:0] exp[5];
        logic [7:0] g;
        c = crc16(8'hFF, 8'hFF);
        exp = '{8'hC3, 8'hFF, 8'hFF, c[7:0], c[15:8]};
        clr();
        idle(3);
        send_sync();
        foreach (exp[i]) send_byte(exp[i]);
        send_eop();
        n_checks++;
        if (got.size() != 5 || n_eop != 1 || n_err != 0 || n_bad != 0) begin
            n_fail++;
            $display("FAIL data0_counts: got bytes=%0d eop=%0d err=%0d bad=%0d expected 5 1 0 0",
                     got.size(), n_eop, n_err, n_bad);
        end
        for (int i = 0; i < 5; i++) begin
            g = i < got.size() ? got[i] : 8'hxx;
            n_checks++;
            if (g !== exp[i]) begin
                n_fail++;
                $display("FAIL data0_byte%0d: got %h expected %h", i, g, exp[i]);
            end
        end
    endtask

    task automatic test_stuff_error();
        logic err_at6;
        clr();
        idle(3);
        send_sync();
        err_at6 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1);
            if (i == 5) err_at6 = post_err;
        end
        n_checks++;
        if (err_at6 !== 1'b1 || n_err != 1 || last_code !== 3'd1 || got.size() != 0) begin
            n_fail++;
            $display("FAIL stuff_err: got at6=%b err=%0d code=%0d bytes=%0d expected 1 1 1 0",
                     err_at6, n_err, last_code, got.size());
        end
        line_j = 1'b1;
        strobe(1'b1, 1'b0);
        send_sync();
        send_byte(8'hD2);
        send_eop();
        n_checks++;
        if (got.size() != 0 || n_eop != 0) begin
            n_fail++;
            $display("FAIL stuff_wait_2j: got bytes=%0d eop=%0d expected 0 0", got.size(), n_eop);
        end
        idle(3);
        send_sync();
        send_byte(8'hD2);
        send_eop();
        n_checks++;
        if (got.size() != 1 || got[0] !== 8'hD2 || n_eop != 1 || n_err != 1 || n_bad != 0) begin
            n_fail++;
            $display("FAIL stuff_recover: got bytes=%0d eop=%0d err=%0d bad=%0d expected 1 1 1 0",
                     got.size(), n_eop, n_err, n_bad);
        end
    endtask

    task automatic test_pid_error();
        clr();
        idle(3);
        send_sync();
        send_byte(8'hC4);
        n_checks++;
        if (post_err !== 1'b1 || post_valid !== 1'b0 || err_code !== 3'd3) begin
            n_fail++;
            $display("FAIL pid_err: got err=%b valid=%b code=%0d expected 1 0 3", post_err, post_valid, err_code);
        end
        send_eop();
        idle(2);
        n_checks++;
        if (got.size() != 0 || n_err != 1 || n_eop != 0 || n_bad != 0) begin
            n_fail++;
            $display("FAIL pid_counts: got bytes=%0d err=%0d eop=%0d bad=%0d expected 0 1 0 0",
                     got.size(), n_err, n_eop, n_bad);
        end
    endtask

    task automatic test_align_error();
        clr();
        idle(3);
        send_sync();
        send_byte(8'hD2);
        send_dbit(1'b1);
        send_dbit(1'b0);
        send_dbit(1'b1);
        strobe(1'b0, 1'b0);
        n_checks++;
        if (post_err !== 1'b1 || err_code !== 3'd2) begin
            n_fail++;
            $display("FAIL align_err: got err=%b code=%0d expected 1 2", post_err, err_code);
        end
        strobe(1'b0, 1'b0);
        idle(3);
        n_checks++;
        if (got.size() != 1 || n_err != 1 || n_eop != 0 || n_bad != 0) begin
            n_fail++;
            $display("FAIL align_counts: got bytes=%0d err=%0d eop=%0d bad=%0d expected 1 1 0 0",
                     got.size(), n_err, n_eop, n_bad);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] v;
        clr();
        idle(3);
        send_sync();
        send_byte(8'hD2);
        v = 8'h5A;
        for (int i = 0; i < 4; i++) send_dbit(v[i]);
        n_checks++;
        if (rx_active !== 1'b1 || rx_data !== 8'hD2) begin
            n_fail++;
            $display("FAIL midrst_pre: got active=%b data=%h expected 1 d2", rx_active, rx_data);
        end
        @(negedge clk);
        rst = 1'b1;
        bit_stb = 1'b1;
        d_p = 1'b0;
        d_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bit_stb = 1'b0;
        n_checks++;
        if ({rx_data, rx_valid, rx_active, rx_eop, rx_error, err_code} !== 14'd0) begin
            n_fail++;
            $display("FAIL midrst_values: got %h expected 0", {rx_data, rx_valid, rx_active, rx_eop, rx_error, err_code});
        end
        got.delete();
        idle(3);
        send_sync();
        send_byte(8'hD2);
        send_eop();
        n_checks++;
        if (got.size() != 1 || got[0] !== 8'hD2 || n_eop != 1 || n_err != 0 || n_bad != 0) begin
            n_fail++;
            $display("FAIL midrst_ack: got bytes=%0d eop=%0d err=%0d bad=%0d expected 1 1 0 0",
                     got.size(), n_eop, n_err, n_bad);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp[5];
        logic [7:0] g;
        exp = '{8'hD2, 8'h01, 8'h02, 8'h03, 8'h04};
        clr();
        idle(3);
        send_sync();
        foreach (exp[i]) send_byte(exp[i]);
        send_eop();
        idle(2);
        n_checks++;
        if (got4.size() != 4 || n_err4 != 1 || code4 !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow_max4: got bytes=%0d err=%0d code=%0d expected 4 1 4", got4.size(), n_err4, code4);
        end
        for (int i = 0; i < 4; i++) begin
            g = i < got4.size() ? got4[i] : 8'hxx;
            n_checks++;
            if (g !== exp[i]) begin
                n_fail++;
                $display("FAIL overflow_byte%0d: got %h expected %h", i, g, exp[i]);
            end
        end
        n_checks++;
        if (got.size() != 5 || n_eop != 1 || n_err != 0) begin
            n_fail++;
            $display("FAIL overflow_default: got bytes=%0d eop=%0d err=%0d expected 5 1 0", got.size(), n_eop, n_err);
        end
    endtask

    task automatic test_crc_error();
        logic [15:0] c;
        c = crc16(8'h12, 8'h34);
        clr();
        idle(3);
        send_sync();
        send_byte(8'h4B);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(c[7:0] ^ 8'h01);
        send_byte(c[15:8]);
        send_eop();
        idle(2);
        n_checks++;
        if (got.size() != 5 || n_bad != 0) begin
            n_fail++;
            $display("FAIL crc_bytes: got bytes=%0d bad=%0d expected 5 0", got.size(), n_bad);
        end
`ifdef USB_RX_CRC16_EN
        n_checks++;
        if (n_err != 1 || last_code !== 3'd5 || n_eop != 0) begin
            n_fail++;
            $display("FAIL crc_err: got err=%0d code=%0d eop=%0d expected 1 5 0", n_err, last_code, n_eop);
        end
`else
        n_checks++;
        if (n_err != 0 || n_eop != 1) begin
            n_fail++;
            $display("FAIL crc_nocheck: got err=%0d eop=%0d expected 0 1", n_err, n_eop);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data0_stuffing();
        test_stuff_error();
        test_pid_error();
        test_align_error();
        test_reset_mid_packet();
        test_overflow();
        test_crc_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_rx_deserializer.md
# usb_rx_deserializer

Receive front-end for the USB controller: it takes synchronized full-speed D+/D− line samples and turns them into a byte stream for the controller's data-transfer path. It does line-state decode, SYNC detection, NRZI decode, bit unstuffing, byte assembly and EOP detection, and classifies receive errors. It sits directly upstream of the controller's receive FIFO.

## Interface
Parameters:
- MAX_BYTES, 1027: maximum bytes per packet, counting the PID. Any byte beyond this count is an overflow error.

Ports:
- clk  in  1  single system clock.
- rst  in  1  reset; synchronous, active-high.
- bit_stb  in  1  one-cycle strobe marking the centre of a bit period. Spacing is at least 4 clk.
- d_p  in  1  D+ sample, already synchronized to clk.
- d_n  in  1  D− sample, already synchronized to clk.
- rx_data  out  8  received byte, LSB is the first bit on the wire. Valid while rx_valid=1.
- rx_valid  out  1  one-cycle pulse per byte. There is no backpressure.
- rx_active  out  1  high from SYNC accepted until EOP or error.
- rx_eop  out  1  one-cycle pulse on a good end of packet.
- rx_error  out  1  one-cycle pulse on abort.
- err_code  out  3  reason for the abort, held until the next rx_active rise:
  - 1: stuff error
  - 2: byte-alignment error
  - 3: PID check error
  - 4: overflow
  - 5: CRC error

## Operation
- Line decode happens on each bit_stb:
  - J = (d_p=1, d_n=0).
  - K = (0,1).
  - SE0 = (0,0).
  - (1,1) = SE1, treated as a stuff error if active, otherwise ignored.
- NRZI decode: the decoded bit is 1 when the line state equals the previous J/K state, and 0 when it differs. The previous state resets to J.
- State machine:
  - IDLE → HUNT on a K following a J.
  - HUNT: shift decoded bits into an 8-bit register. The pattern 0000_0001 (KJKJKJKK) → DATA. An SE0 or 8 bits without a match → IDLE.
  - DATA: unstuff, assemble bytes, check errors.
  - SE0 → EOP.
  - EOP: SE0 followed by J → IDLE with rx_eop. Any other sequence → error.
  - ERR_WAIT: entered on any error. Stay until 2 consecutive J strobes, then → IDLE.
- Unstuffing: count consecutive decoded 1s, with SYNC's final 1 counting as the first.
  - After six 1s, the next bit is discarded if it is 0 and the count clears.
  - If that bit is 1 → error 1.
- Byte assembly: shift right and count bits 0–7. At the 8th bit, present the byte on rx_data and pulse rx_valid.
- The byte counter saturates at MAX_BYTES+1; reaching MAX_BYTES+1 → error 4.
- First byte is the PID: require PID[7:4] == ~PID[3:0], else error 3, and that byte is not delivered.
- SE0 in DATA with a nonzero partial bit count → error 2. SE0 with zero bytes also → error 2.
- rx_active drops in the same cycle that rx_eop or rx_error pulses.

## Timing
- Reset values:
  - rx_data=0, rx_valid=0, rx_active=0, rx_eop=0, rx_error=0, err_code=0.
  - State IDLE, previous line state J, all counters 0.
- Latency:
  - rx_valid pulses 1 clk after the bit_stb carrying a byte's final unstuffed bit.
  - rx_active rises 1 clk after the SYNC-completing strobe.
  - rx_eop pulses 1 clk after the J strobe that ends the EOP.
  - rx_error pulses 1 clk after the offending strobe.
- A stuffed bit delays the byte by one bit period and never generates a pulse.
- rst asserted mid-packet: the next cycle shows reset values, with no rx_eop or rx_error pulse.
- If bit_stb coincides with rst, the strobe is ignored.
- rx_eop, rx_error and rx_valid are mutually exclusive in any cycle.

## Configuration
- USB_RX_CRC16_EN defined:
  - For DATA PIDs (PID[1:0]==2'b11), compute CRC16 over every bit after the PID, LSB first: polynomial 0x8005, initial value 0xFFFF.
  - At a valid EOP, the residual must equal 0x800D. Otherwise error 5 replaces rx_eop.
  - Token and handshake PIDs are not checked.
- USB_RX_CRC16_EN undefined: no CRC logic is built, error 5 never occurs, and every valid EOP gives rx_eop.
- Byte delivery is identical in both builds; the two CRC bytes are always passed through.

## Test plan
- ACK packet: SYNC + PID 0xD2 + EOP → exactly one rx_valid with rx_data=0xD2, then rx_eop; rx_active spans both.
- DATA0 (PID 0xC3) with payload 0xFF,0xFF and a correct CRC → stuffed bits removed, 5 bytes delivered (PID, 2 data, 2 CRC), then rx_eop in both builds.
- Seven consecutive decoded 1s after SYNC → rx_error with err_code=1. No further rx_valid until 2 J strobes, then the next packet is received normally.
- PID 0xC4 → rx_error with err_code=3, and no rx_valid for that byte.
- SE0 after PID + 3 bits → err_code=2.
- MAX_BYTES=4 with a 5-byte packet → the 4 bytes are delivered, then err_code=4.
- DATA1 (PID 0x4B) with a corrupted CRC byte → err_code=5 when USB_RX_CRC16_EN is defined; rx_eop when it is undefined.
- rst pulsed during byte 2 → all outputs 0 the next cycle, and a following clean ACK is received correctly.
